add_arbiter: RTL

ADD_ARBITER -- requirements
Module: add_arbiter

---
 rtl/add_arbiter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/add_arbiter.sv
// add_arbiter: shares one pipelined adder among NUM_REQ requesters.
// Combinational one-hot grant (round-robin by default), a LATENCY-deep tag
// pipeline that routes each adder result back to its requester, and an
// in-flight counter that drives busy.
// Build option: define ADD_ARB_FIXED_PRIO_EN for fixed priority
// (lowest index wins); ports and timing are the same in both builds.
//
// Handshake: request i is accepted on a rising edge where req_valid[i] and
// req_ready[i] are both high; req_ready never depends on req_data, and a
// response is a one-cycle resp_valid pulse with no backpressure.
module add_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 16,
    parameter int LATENCY = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     add_in_valid,
    output logic [WIDTH-1:0]         add_in_data,
    input  logic [WIDTH-1:0]         add_result,
    output logic [NUM_REQ-1:0]       resp_valid,
    output logic [WIDTH-1:0]         resp_data,
    output logic                     busy
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(LATENCY + 1) + 1;

    logic [IW-1:0] grant_idx;
    logic          grant_found;
    logic [IW-1:0] cand;

    logic          tag_v  [LATENCY];
    logic [IW-1:0] tag_id [LATENCY];
    logic [CW-1:0] count;
    logic          resp_fire;

`ifdef ADD_ARB_FIXED_PRIO_EN
    // Fixed priority: first valid requester from index 0 upward wins.
    always_comb begin
        grant_idx   = '0;
        grant_found = 1'b0;
        cand        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = IW'(k);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end
`else
    logic [IW-1:0] last_grant;
    logic [IW-1:0] ptr;

    // While rst is high the search already starts from the reset pointer,
    // so requester 0 has priority during and right after reset.
    assign ptr = rst ? IW'(NUM_REQ - 1) : last_grant;

    // Round-robin: search from ptr+1 upward with wrap; first valid wins.
    always_comb begin
        grant_idx   = '0;
        grant_found = 1'b0;
        cand        = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IW'((int'(ptr) + k) % NUM_REQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Round-robin pointer: moves to the granted index on every accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= IW'(NUM_REQ - 1);
        end else if (grant_found) begin
            last_grant <= grant_idx;
        end
    end
`endif

    assign req_ready    = grant_found ? (NUM_REQ'(1) << grant_idx) : '0;
    assign add_in_valid = grant_found;

    // Operand mux: granted requester's data, zero when nothing is granted.
    always_comb begin
        add_in_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_found && (IW'(i) == grant_idx)) begin
                add_in_data = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Tag pipeline: shifts every cycle, accepts enter at stage 0, so the
    // last stage lines up with the adder result LATENCY edges later.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                tag_v[i]  <= 1'b0;
                tag_id[i] <= '0;
            end
        end else begin
            tag_v[0]  <= grant_found;
            tag_id[0] <= grant_idx;
            for (int i = 1; i < LATENCY; i++) begin
                tag_v[i]  <= tag_v[i-1];
                tag_id[i] <= tag_id[i-1];
            end
        end
    end

    // Gated by rst so in-flight tags never surface while reset is held.
    assign resp_fire  = tag_v[LATENCY-1] && !rst;
    assign resp_valid = resp_fire ? (NUM_REQ'(1) << tag_id[LATENCY-1]) : '0;
    assign resp_data  = add_result;

    // In-flight counter: +1 on accept, -1 on response, hold when both.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else begin
            case ({grant_found, resp_fire})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign busy = !rst && (count != '0);

endmodule
